// File: rtl/host_bus_arbiter.sv
// Round-robin arbiter sharing one host memory port between N_REQ bus masters.
// One transaction in flight at a time; a watchdog aborts transactions that never complete.
module host_bus_arbiter #(
   parameter int          N_REQ          = 3,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         s_valid,
   input  logic [N_REQ*32-1:0]      s_addr,
   input  logic [N_REQ*32-1:0]      s_wdata,
   input  logic [N_REQ*4-1:0]       s_wstrb,
   output logic [N_REQ-1:0]         s_ready,
   output logic [31:0]              s_rdata,
   output logic                     m_valid,
   output logic [31:0]              m_addr,
   output logic [31:0]              m_wdata,
   output logic [3:0]               m_wstrb,
   input  logic                     m_ready,
   input  logic [31:0]              m_rdata,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     timeout_pulse,
   output logic [7:0]               timeout_count
);

   localparam int GW    = $clog2(N_REQ);
   localparam int WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
   localparam bit   TO_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, COOL = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_ptr;
   logic [GW-1:0]   win_idx;
   logic [GW-1:0]   cand;
   int              cand_i;
   logic            win_found;
   logic            grant_en;
   logic            done_ok;
   logic            done_to;
   logic [WD_W-1:0] wd_q;

   logic [31:0] addr_a  [N_REQ];
   logic [31:0] wdata_a [N_REQ];
   logic [3:0]  wstrb_a [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign addr_a[i]  = s_addr[32*i +: 32];
      assign wdata_a[i] = s_wdata[32*i +: 32];
      assign wstrb_a[i] = s_wstrb[4*i +: 4];
   end

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // First valid requester at or above rr_ptr, wrapping at N_REQ (not at 2**GW).
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_i    = 0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_i = int'(rr_ptr) + k;
         if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
         cand = GW'(cand_i);
         if (!win_found && s_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A completion on the watchdog's final cycle takes priority over the abort.
   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      done_ok  = 1'b0;
      done_to  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_en = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (m_ready) begin
               done_ok = 1'b1;
               state_d = COOL;
            end else if (TO_EN && (wd_q == WD_MAX)) begin
               done_to = 1'b1;
               state_d = COOL;
            end
         end
         COOL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid       <= 1'b0;
         m_addr        <= '0;
         m_wdata       <= '0;
         m_wstrb       <= '0;
         s_ready       <= '0;
         s_rdata       <= '0;
         grant_id      <= '0;
         rr_ptr        <= '0;
         wd_q          <= '0;
         timeout_pulse <= 1'b0;
         timeout_count <= '0;
      end else begin
         s_ready       <= '0;
         timeout_pulse <= 1'b0;
         if (grant_en) begin
            m_valid  <= 1'b1;
            m_addr   <= addr_a[win_idx];
            m_wdata  <= wdata_a[win_idx];
            m_wstrb  <= wstrb_a[win_idx];
            grant_id <= win_idx;
            wd_q     <= '0;
         end else if (done_ok || done_to) begin
            m_valid <= 1'b0;
            s_ready <= N_REQ'(1) << grant_id;
            s_rdata <= done_ok ? m_rdata : ERR_RDATA;
            rr_ptr  <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            if (done_to) begin
               timeout_pulse <= 1'b1;
               timeout_count <= sat_inc8(timeout_count);
            end
         end else if (state_q == BUSY && wd_q != WD_MAX) begin
            wd_q <= wd_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Randomised and directed bench for host_bus_arbiter against a transaction-level reference model.
module tb_host_bus_arbiter;

   localparam int          N   = 3;
   localparam int          TMO = 16;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic            sys_clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_valid;
   logic [N*32-1:0] s_addr;
   logic [N*32-1:0] s_wdata;
   logic [N*4-1:0]  s_wstrb;
   logic [N-1:0]    s_ready;
   logic [31:0]     s_rdata;
   logic            m_valid;
   logic [31:0]     m_addr;
   logic [31:0]     m_wdata;
   logic [3:0]      m_wstrb;
   logic            m_ready;
   logic [31:0]     m_rdata;
   logic [1:0]      grant_id;
   logic            timeout_pulse;
   logic [7:0]      timeout_count;

   // requester-side stimulus
   logic        rv [N];
   logic [31:0] ra [N];
   logic [31:0] rw [N];
   logic [3:0]  rs [N];
   int          rem [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign s_valid[g]         = rv[g];
      assign s_addr[32*g +: 32]  = ra[g];
      assign s_wdata[32*g +: 32] = rw[g];
      assign s_wstrb[4*g +: 4]   = rs[g];
   end

   host_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .grant_id(grant_id), .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp, n_mis;

   // reference model: arbiter is either free (from edge free_at on) or owned by one requester
   int          edge_n, owner, gnt_edge, free_at, rr, last_gnt, tcount;
   logic        e_mvalid, e_tpulse;
   logic [N-1:0] e_sready;
   logic [31:0] e_rdata, e_maddr, e_mwdata;
   logic [3:0]  e_mwstrb;

   // bridge model and mode flags
   int   bcnt, cur_w, fix_w;
   logic rand_mode, late_inj;

   // event log
   int          gq[$], dq[$], rq[$];
   logic [31:0] aq[$];
   int          sr_edge, tp_cnt;
   logic [31:0] last_rd;
   logic        prev_mv, mv_at_sr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      owner = -1; rr = 0; edge_n = 0; free_at = 1; last_gnt = 0; tcount = 0;
      e_mvalid = 1'b0; e_tpulse = 1'b0; e_sready = '0; e_rdata = '0;
      e_maddr = '0; e_mwdata = '0; e_mwstrb = '0; prev_mv = 1'b0;
   endtask

   task automatic clear_log();
      gq.delete(); dq.delete(); rq.delete(); aq.delete();
      sr_edge = -1; tp_cnt = 0; last_rd = '0; mv_at_sr = 1'b0;
   endtask

   task automatic finish_txn(input logic [31:0] d, input logic aborted);
      e_sready[owner] = 1'b1;
      e_rdata = d;
      if (aborted) begin
         e_tpulse = 1'b1;
         if (tcount < 255) tcount++;
      end
      rr      = (owner + 1) % N;
      free_at = edge_n + 2;
      owner   = -1;
   endtask

   // Advance the model by one clock edge using the inputs that were present at that edge.
   task automatic model_edge();
      int w;
      edge_n++;
      e_sready = '0;
      e_tpulse = 1'b0;
      if (owner >= 0) begin
         if (m_ready === 1'b1)             finish_txn(m_rdata, 1'b0);
         else if (edge_n - gnt_edge > TMO) finish_txn(ERR, 1'b1);
      end else if (edge_n >= free_at) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && rv[(rr + k) % N]) w = (rr + k) % N;
         if (w >= 0) begin
            owner = w; gnt_edge = edge_n; last_gnt = w;
            e_maddr = ra[w]; e_mwdata = rw[w]; e_mwstrb = rs[w];
         end
      end
      e_mvalid = (owner >= 0);
   endtask

   task automatic compare();
      chk("m_valid", m_valid, e_mvalid);
      chk("s_ready", s_ready, e_sready);
      chk("grant_id", grant_id, last_gnt);
      chk("timeout_pulse", timeout_pulse, e_tpulse);
      chk("timeout_count", timeout_count, tcount);
      if (e_mvalid) begin
         chk("m_addr", m_addr, e_maddr);
         chk("m_wdata", m_wdata, e_mwdata);
         chk("m_wstrb", m_wstrb, e_mwstrb);
      end
      if (e_sready != '0) chk("s_rdata", s_rdata, e_rdata);
      if (m_valid && !prev_mv) begin
         gq.push_back(int'(grant_id)); rq.push_back(edge_n); aq.push_back(m_addr);
      end
      if (s_ready != '0) begin
         for (int i = N - 1; i >= 0; i--) if (s_ready[i]) sr_edge = i;
         dq.push_back(sr_edge);
         sr_edge  = edge_n;
         last_rd  = s_rdata;
         mv_at_sr = m_valid;
      end
      if (timeout_pulse) tp_cnt++;
      prev_mv = m_valid;
   endtask

   task automatic new_txn(input int i);
      rv[i] = 1'b1;
      ra[i] = $urandom;
      rw[i] = $urandom;
      rs[i] = 4'($urandom_range(0, 15));
   endtask

   function automatic int pick_wait();
      int r;
      r = $urandom_range(0, 11);
      if (r == 10) return TMO;
      if (r == 11) return TMO + 1;
      return r % 5;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (e_sready[i]) begin
            rem[i]--;
            if (rem[i] > 0) new_txn(i);
            else rv[i] = 1'b0;
         end else if (rand_mode) begin
            if (!rv[i] && $urandom_range(0, 3) == 0) begin
               rem[i] = 1; new_txn(i);
            end else if (rv[i] && owner != i && $urandom_range(0, 15) == 0) begin
               rv[i] = 1'b0;
            end
         end
      end
      m_ready = 1'b0;
      m_rdata = $urandom;
      if (late_inj && timeout_pulse) begin
         m_ready = 1'b1;
      end else if (m_valid) begin
         if (bcnt < 0) begin
            bcnt  = 0;
            cur_w = rand_mode ? pick_wait() : fix_w;
         end
         if (cur_w >= 0 && bcnt == cur_w) begin
            m_ready = 1'b1;
            m_rdata = m_addr | 32'hA000_0000;
         end
         bcnt++;
      end else begin
         bcnt = -1;
      end
   endtask

   task automatic step();
      @(negedge sys_clk);
      model_edge();
      compare();
      drive();
   endtask

   task automatic run_phase(input int max_cyc);
      logic done;
      done = 1'b0;
      for (int c = 0; c < max_cyc && !done; c++) begin
         step();
         done = (owner < 0);
         for (int i = 0; i < N; i++) if (rv[i]) done = 1'b0;
      end
      chk("phase_drained", done, 1);
      repeat (2) step();
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   logic [31:0] wa [3];
   logic [31:0] exp_rd;
   logic        got;
   int          sv_edge;

   initial begin
      n_cmp = 0; n_mis = 0;
      rand_mode = 1'b0; late_inj = 1'b0; fix_w = 0; bcnt = -1; cur_w = 0;
      for (int i = 0; i < N; i++) begin
         rv[i] = 1'b0; ra[i] = '0; rw[i] = '0; rs[i] = '0; rem[i] = 0;
      end
      m_ready = 1'b0; m_rdata = '0;
      rst_n = 1'b0;
      model_reset();
      clear_log();
      repeat (3) @(negedge sys_clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_s_rdata", s_rdata, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_wstrb", m_wstrb, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_t_pulse", timeout_pulse, 0);
      chk("rst_t_count", timeout_count, 0);
      rst_n = 1'b1;

      // three simultaneous writes
      wa[0] = 32'h0011_1111; wa[1] = 32'h0122_2222; wa[2] = 32'h0F33_3333;
      for (int i = 0; i < N; i++) begin
         rem[i] = 1; new_txn(i); ra[i] = wa[i]; rs[i] = 4'hF;
      end
      fix_w = 1;
      run_phase(100);
      chk("wr_grants", gq.size(), 3);
      chk("wr_dones", dq.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("wr_grant_order", qat(gq, i), i);
         chk("wr_done_order", qat(dq, i), i);
         chk("wr_addr_seq", (i < aq.size()) ? aq[i] : 32'hFFFF_FFFF, wa[i]);
      end

      // fairness between requesters 0 and 2, zero-wait bridge
      clear_log();
      rem[0] = 5; new_txn(0); rem[2] = 5; new_txn(2);
      fix_w = 0;
      run_phase(200);
      chk("fair_grants", gq.size(), 10);
      for (int i = 0; i < 10; i++) chk("fair_grant_seq", qat(gq, i), (i % 2 == 0) ? 0 : 2);
      for (int i = 1; i < 10; i++) chk("fair_spacing", qat(rq, i) - qat(rq, i - 1), 3);

      // single read with two wait cycles
      clear_log();
      rem[0] = 1; new_txn(0); ra[0] = 32'h0012_3456; rs[0] = 4'h0;
      fix_w = 2;
      sv_edge = edge_n;
      run_phase(50);
      chk("rd_latency", qat(rq, 0) - sv_edge, 1);
      chk("rd_pulses", dq.size(), 1);
      chk("rd_requester", qat(dq, 0), 0);
      chk("rd_data", last_rd, 32'hA012_3456);
      chk("rd_resp_edge", sr_edge - qat(rq, 0), 3);
      chk("rd_mvalid_at_ready", mv_at_sr, 0);

      // watchdog abort followed by a late m_ready
      clear_log();
      rem[1] = 1; new_txn(1);
      fix_w = -1; late_inj = 1'b1;
      run_phase(60);
      late_inj = 1'b0;
      chk("to_resp_edge", sr_edge - qat(rq, 0), TMO + 1);
      chk("to_rdata", last_rd, ERR);
      chk("to_pulses", tp_cnt, 1);
      chk("to_count", timeout_count, 1);
      chk("to_ready_pulses", dq.size(), 1);

      // m_ready on exactly the timeout cycle
      clear_log();
      rem[2] = 1; new_txn(2); ra[2] = 32'h0555_0000;
      exp_rd = ra[2] | 32'hA000_0000;
      fix_w = TMO;
      run_phase(60);
      chk("sim_rdata", last_rd, exp_rd);
      chk("sim_pulses", tp_cnt, 0);
      chk("sim_count", timeout_count, 1);
      chk("sim_resp_edge", sr_edge - qat(rq, 0), TMO + 1);

      // randomised traffic
      clear_log();
      rand_mode = 1'b1;
      repeat (2000) step();
      rand_mode = 1'b0;
      fix_w = 2;
      run_phase(400);

      // abort counter saturation
      clear_log();
      rem[0] = 260; new_txn(0);
      fix_w = -1;
      run_phase(6000);
      chk("sat_count", timeout_count, 255);
      chk("sat_dones", dq.size(), 260);

      // asynchronous reset while BUSY
      clear_log();
      rem[2] = 1; new_txn(2);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         step();
         got = m_valid;
      end
      chk("rst_reached_busy", got, 1);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_s_ready", s_ready, 0);
      chk("arst_t_count", timeout_count, 0);
      for (int i = 0; i < N; i++) begin
         rv[i] = 1'b0; rem[i] = 0;
      end
      m_ready = 1'b0; bcnt = -1;
      @(negedge sys_clk);
      rst_n = 1'b1;
      model_reset();
      clear_log();
      rem[0] = 1; new_txn(0); rem[1] = 1; new_txn(1);
      fix_w = 0;
      run_phase(100);
      chk("post_rst_first", qat(gq, 0), 0);
      chk("post_rst_second", qat(gq, 1), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL sim_time_limit: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/host_bus_arbiter.md
Name: host_bus_arbiter

Overview:
- Shares the single host memory port of apb_bridge_top between N_REQ bus masters (MCU core, DMA engine, debug port).
- Uses work-conserving round-robin arbitration: exactly one transaction is in flight downstream at a time.
- Adds a per-transaction timeout watchdog, so a hung APB peripheral cannot stall the host bus.
- Sits between the requesters and apb_bridge_top in the receiver top level.

Parameters:
- N_REQ, 3, number of requester ports (2..8).
- TIMEOUT_CYCLES, 1024, max cycles in BUSY before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on an aborted transaction.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  N_REQ  per-requester request valid.
- s_addr  in  N_REQ*32  per-requester address; requester i occupies bits [32i+31:32i].
- s_wdata  in  N_REQ*32  per-requester write data.
- s_wstrb  in  N_REQ*4  per-requester byte strobes; 0 = read.
- s_ready  out  N_REQ  per-requester completion pulse.
- s_rdata  out  32  read data, shared, valid only with a s_ready pulse.
- m_valid  out  1  to bridge host_valid.
- m_addr  out  32  to bridge host_addr.
- m_wdata  out  32  to bridge host_wdata.
- m_wstrb  out  4  to bridge host_wstrb.
- m_ready  in  1  from bridge host_ready.
- m_rdata  in  32  from bridge host_rdata.
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- timeout_pulse  out  1  one-cycle pulse on abort.
- timeout_count  out  8  saturating count of aborts.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; rr_ptr=0; watchdog counter 0.
- Requester contract: hold s_valid, addr, wdata, wstrb stable until its s_ready pulse; may drop s_valid on any edge after the pulse.
- FSM has three states: IDLE, BUSY, COOL.
- IDLE:
  - If any s_valid is high, pick the first set bit searching from rr_ptr upward with wrap.
  - Register the winner's addr/wdata/wstrb onto m_*.
  - Set m_valid=1, grant_id=g, clear the watchdog, go to BUSY.
  - m_valid is high on the cycle after s_valid is sampled (1-cycle arbitration latency).
  - If no s_valid is high, stay in IDLE.
- BUSY:
  - m_* are held stable and the watchdog increments each cycle.
  - On m_ready=1:
    - Capture s_rdata<=m_rdata.
    - Pulse s_ready[g]=1 for exactly one cycle (next cycle).
    - Set m_valid=0 and rr_ptr=(g+1) mod N_REQ; go to COOL.
  - On timeout, when TIMEOUT_CYCLES!=0, the counter reaches TIMEOUT_CYCLES and m_ready=0:
    - Set s_rdata=ERR_RDATA and pulse s_ready[g].
    - Pulse timeout_pulse; timeout_count+=1, saturating at 255.
    - Set m_valid=0, advance rr_ptr, go to COOL.
  - If m_ready rises on the same cycle the timeout is reached, the normal completion wins and no timeout is counted.
- COOL: one dead cycle; no grant is made and m_ready is ignored. This absorbs the requester's valid-drop latency. Next state is IDLE.
- A late m_ready arriving in COOL or IDLE, after an abort, is ignored.
- s_ready for non-granted requesters stays 0 at all times; s_ready is one-hot or zero.
- Minimum back-to-back throughput: 3 cycles per transaction with a 0-wait bridge.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
- A requester dropping s_valid while not granted is legal and is simply not considered.
- A requester dropping s_valid while granted violates the contract; the transaction still completes downstream.
- Asserting rst_n low mid-transaction forces IDLE, m_valid=0 and s_ready=0 asynchronously, and clears timeout_count.

Test Plan:
- Single requester 0 reads 32'h0012_3456, bridge answers 32'hA012_3456 after 2 wait cycles:
  - m_valid rises 1 cycle after s_valid[0].
  - s_ready[0] is a one-cycle pulse with s_rdata=32'hA012_3456.
  - m_valid is low on the following cycle.
- All 3 requesters assert valid simultaneously with writes to 32'h0011_1111, 32'h0122_2222 and 32'h0F33_3333:
  - m_addr sequence is 0→1→2.
  - Each s_ready fires exactly once, in the same order.
  - At most one m_valid transaction is in flight at any time.
- Fairness: requesters 0 and 2 are held continuously valid for 10 transactions → grant_id alternates 0,2,0,2…, with no starvation.
- TIMEOUT_CYCLES=16 and the bridge never asserts m_ready:
  - s_ready pulses 17 cycles after m_valid rose, with s_rdata=32'hDEAD_BEEF.
  - timeout_pulse=1 and timeout_count=1.
  - A late m_ready one cycle later produces no extra s_ready.
- Simultaneous event: m_ready arrives on exactly the timeout cycle → normal completion with real m_rdata, timeout_count unchanged.
- rst_n asserted during BUSY → m_valid, s_ready and timeout_count read 0 immediately; after release a new request is granted normally with rr_ptr=0.
